// File: rtl/bist_lfsr_tpg.sv
`default_nettype none
// ============================================================================
// Module      : bist_lfsr_tpg
// Description : BIST test-pattern generator. A Fibonacci LFSR, sequenced by
//               a start/done FSM, issues a programmable number of
//               pseudo-random patterns, one per unheld cycle, with a valid
//               strobe that also clocks the downstream MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_lfsr_tpg #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
    parameter logic [WIDTH-1:0] SEED     = 4'b0001,
    parameter int              CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 hold,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    input  logic [CNT_WIDTH-1:0] num_patterns,
    output logic [WIDTH-1:0]     pattern,
    output logic                 pattern_valid,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pattern_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     lfsr;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] target;

    logic                 launch;     // start accepted this cycle
    logic                 step;       // a pattern is issued this cycle
    logic                 load_seed;  // seed_load honoured this cycle
    logic                 last;       // the pattern issued now is the final one

    assign last = (count == (target - CNT_ONE));

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle control strobes; abort overrides all
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        step       = 1'b0;
        load_seed  = seed_load && (state != S_RUN);
        case (state)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    launch     = 1'b1;
                    state_next = (num_patterns != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (!hold && !abort) begin
                    step = 1'b1;
                    if (last) begin
                        state_next = S_DONE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    // LFSR: an all-zero seed would lock up, so it falls back to SEED
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED;
        end else if (load_seed) begin
            lfsr <= (seed == '0) ? SEED : seed;
        end else if (step) begin
            lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
        end
    end

    // Issued-pattern counter, cleared on launch and saturating at full scale
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (launch) begin
            count <= '0;
        end else if (step && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

    // Run length captured when a non-empty run is launched
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            target <= '0;
        end else if (launch && (num_patterns != '0)) begin
            target <= num_patterns;
        end
    end

    assign pattern       = lfsr;
    assign pattern_valid = (state == S_RUN) && !hold;
    assign busy          = (state == S_RUN);
    assign done          = (state == S_DONE);
    assign pattern_count = count;

endmodule
`default_nettype wire

// File: tb/tb_bist_lfsr_tpg.sv
`default_nettype none
// ============================================================================
// Module      : tb_bist_lfsr_tpg
// Description : Self-checking bench for bist_lfsr_tpg. Expected patterns come
//               from the published 15-state sequence table, not from a
//               shift/XOR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_lfsr_tpg;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic       seed_load = 1'b0;
    logic [3:0] seed = 4'h0;
    logic [7:0] num_patterns = 8'h0;
    logic [3:0] pattern;
    logic       pattern_valid;
    logic       busy;
    logic       done;
    logic [7:0] pattern_count;

    int checks = 0;
    int passed = 0;

    // Reference: the documented default sequence starting from 0001
    logic [3:0] seq_tab [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    logic [3:0] model_q = 4'h1;

    bist_lfsr_tpg dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .hold          (hold),
        .seed_load     (seed_load),
        .seed          (seed),
        .num_patterns  (num_patterns),
        .pattern       (pattern),
        .pattern_valid (pattern_valid),
        .busy          (busy),
        .done          (done),
        .pattern_count (pattern_count)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] next_pat(input logic [3:0] p);
        for (int i = 0; i < 15; i++) begin
            if (seq_tab[i] == p) return seq_tab[(i + 1) % 15];
        end
        return 4'h0;
    endfunction

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({pattern, pattern_valid, busy, done, pattern_count} !== {4'h1, 1'b0, 1'b0, 1'b0, 8'h0})
            $display("FAIL reset_hold: got pat=%h v=%b b=%b d=%b cnt=%0d want pat=1 v=0 b=0 d=0 cnt=0",
                     pattern, pattern_valid, busy, done, pattern_count);
        else passed++;
        #10 reset = 1'b1;
        cycle();
        @(negedge clock);
        checks++;
        if ({pattern, pattern_valid, busy, done} !== {4'h1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_release: got pat=%h v=%b b=%b d=%b want pat=1 idle",
                     pattern, pattern_valid, busy, done);
        else passed++;
    endtask

    // Launch one run from IDLE/DONE and collect its valid patterns
    task automatic run_pattern(input int n, input bit do_seed, input logic [3:0] sv,
                               input int hold_pct, input int sl_pct, input string name);
        logic [3:0] exp_q[$];
        logic [3:0] obs[$];
        int last_valid = -1;
        int done_at = -1;
        int m;
        if (do_seed) model_q = (sv == 4'h0) ? 4'h1 : sv;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_q);
            model_q = next_pat(model_q);
        end
        start = 1'b1; num_patterns = 8'(n); seed_load = do_seed; seed = sv;
        cycle();
        start = 1'b0; seed_load = 1'b0;
        for (int c = 0; c < n * 4 + 20; c++) begin
            hold = ($urandom_range(99) < hold_pct);
            seed_load = ($urandom_range(99) < sl_pct);
            seed = 4'($urandom);
            @(negedge clock);
            if (pattern_valid) begin
                obs.push_back(pattern);
                last_valid = c;
            end
            checks++;
            if (done && (busy || pattern_valid))
                $display("FAIL %s_excl: got d=%b b=%b v=%b want done exclusive", name, done, busy, pattern_valid);
            else passed++;
            if (done) begin
                done_at = c;
                break;
            end
            cycle();
        end
        hold = 1'b0; seed_load = 1'b0;
        checks++;
        if (done_at < 0) $display("FAIL %s_timeout: got no done want done", name);
        else passed++;
        checks++;
        if (obs.size() != n) $display("FAIL %s_nvalid: got %0d want %0d", name, obs.size(), n);
        else passed++;
        m = (obs.size() < n) ? obs.size() : n;
        for (int i = 0; i < m; i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) $display("FAIL %s_pat%0d: got %h want %h", name, i, obs[i], exp_q[i]);
            else passed++;
        end
        checks++;
        if (done_at != last_valid + 1)
            $display("FAIL %s_done_lat: got done at %0d want %0d", name, done_at, last_valid + 1);
        else passed++;
        checks++;
        if ({pattern_count, pattern, busy} !== {8'(n), model_q, 1'b0})
            $display("FAIL %s_end: got cnt=%0d pat=%h b=%b want cnt=%0d pat=%h b=0",
                     name, pattern_count, pattern, busy, n, model_q);
        else passed++;
    endtask

    task automatic test_full_sequence();
        run_pattern(15, 1'b0, 4'h0, 0, 0, "full15");
    endtask

    task automatic test_seed();
        seed_load = 1'b1; seed = 4'b1010;
        cycle();
        seed_load = 1'b0;
        model_q = 4'b1010;
        @(negedge clock);
        checks++;
        if (pattern !== 4'b1010) $display("FAIL seed_load: got %h want a", pattern);
        else passed++;
        run_pattern(3, 1'b0, 4'h0, 0, 0, "seed1010");
        run_pattern(1, 1'b1, 4'h0, 0, 0, "seed0000");
    endtask

    task automatic test_hold();
        bit         hs [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        bit         ev [8] = '{1, 1, 0, 0, 1, 1, 1, 0};
        logic [3:0] ep [7] = '{4'h1, 4'h3, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};
        start = 1'b1; num_patterns = 8'd5; seed_load = 1'b1; seed = 4'h1;
        cycle();
        start = 1'b0; seed_load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            hold = hs[c];
            @(negedge clock);
            checks++;
            if (pattern_valid !== ev[c]) $display("FAIL hold_valid%0d: got %b want %b", c, pattern_valid, ev[c]);
            else passed++;
            if (c < 7) begin
                checks++;
                if (pattern !== ep[c]) $display("FAIL hold_pat%0d: got %h want %h", c, pattern, ep[c]);
                else passed++;
            end
            cycle();
        end
        hold = 1'b0;
        @(negedge clock);
        checks++;
        if ({done, pattern_count, pattern} !== {1'b1, 8'd5, 4'hD})
            $display("FAIL hold_end: got d=%b cnt=%0d pat=%h want d=1 cnt=5 pat=d", done, pattern_count, pattern);
        else passed++;
        model_q = 4'hD;
    endtask

    task automatic test_abort();
        start = 1'b1; num_patterns = 8'd10; seed_load = 1'b1; seed = 4'h1;
        cycle();
        start = 1'b0; seed_load = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        abort = 1'b1;
        @(negedge clock);
        checks++;
        if ({pattern_valid, pattern} !== {1'b1, 4'hF})
            $display("FAIL abort_cycle: got v=%b pat=%h want v=1 pat=f", pattern_valid, pattern);
        else passed++;
        cycle();
        abort = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, pattern_valid, pattern_count, pattern} !== {1'b0, 1'b0, 1'b0, 8'd3, 4'hF})
            $display("FAIL abort_idle: got b=%b d=%b v=%b cnt=%0d pat=%h want 0 0 0 3 f",
                     busy, done, pattern_valid, pattern_count, pattern);
        else passed++;
        // abort beats start
        abort = 1'b1; start = 1'b1; num_patterns = 8'd4;
        cycle();
        abort = 1'b0; start = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, pattern_count} !== {1'b0, 1'b0, 8'd3})
            $display("FAIL abort_prio: got b=%b d=%b cnt=%0d want 0 0 3", busy, done, pattern_count);
        else passed++;
        model_q = 4'hF;
        run_pattern(2, 1'b0, 4'h0, 0, 0, "after_abort");
    endtask

    task automatic test_zero();
        run_pattern(0, 1'b0, 4'h0, 0, 0, "zero");
        run_pattern(2, 1'b0, 4'h0, 0, 0, "b2b");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++)
            run_pattern(int'($urandom_range(40, 1)), bit'($urandom_range(1)), 4'($urandom), 30, 30, "rand");
        run_pattern(255, 1'b0, 4'h0, 0, 0, "wrap255");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; num_patterns = 8'd20;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({pattern, pattern_valid, busy, done, pattern_count} !== {4'h1, 1'b0, 1'b0, 1'b0, 8'h0})
            $display("FAIL reset_mid: got pat=%h v=%b b=%b d=%b cnt=%0d want 1 0 0 0 0",
                     pattern, pattern_valid, busy, done, pattern_count);
        else passed++;
        #2 reset = 1'b1;
        model_q = 4'h1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            @(negedge clock);
            checks++;
            if ({pattern_valid, busy, done, pattern} !== {1'b0, 1'b0, 1'b0, 4'h1})
                $display("FAIL reset_quiet%0d: got v=%b b=%b d=%b pat=%h want 0 0 0 1",
                         c, pattern_valid, busy, done, pattern);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_seed();
        test_hold();
        test_abort();
        test_zero();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bist_lfsr_tpg.md
Name: bist_lfsr_tpg

Overview:
- Test-pattern generator for the BIST datapath. It is the stimulus end that drives the circuit under test, whose responses the MISR compacts.
- A Fibonacci LFSR, run by a small start/done FSM, emits a programmable number of pseudo-random patterns, one per enabled cycle.
- The same valid strobe clocks the MISR, so the MISR signature is taken over exactly the patterns issued.

Parameters:
- WIDTH, 4: LFSR / pattern width in bits.
- TAPS, 4'b1001: feedback mask. feedback = XOR-reduce(Q & TAPS). Default gives the maximal-length 15-state sequence.
- SEED, 4'b0001: reset value of the LFSR.
- CNT_WIDTH, 8: width of pattern counter and num_patterns.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  begins a run; sampled in IDLE or DONE.
- abort  input  1  returns the FSM to IDLE from any state.
- hold  input  1  stall from downstream; freezes the LFSR and counter in RUN.
- seed_load  input  1  loads seed into the LFSR; honoured in IDLE/DONE only.
- seed  input  WIDTH  seed value for seed_load.
- num_patterns  input  CNT_WIDTH  patterns per run; sampled on start.
- pattern  output  WIDTH  current LFSR state, registered.
- pattern_valid  output  1  pattern is a new test vector this cycle.
- busy  output  1  FSM in RUN.
- done  output  1  run complete; level, held in DONE.
- pattern_count  output  CNT_WIDTH  number of patterns issued in the current or last run.

Behaviour:
- Reset values (async, reset=0): state=IDLE, LFSR=SEED, pattern=SEED, pattern_valid=0, busy=0, done=0, pattern_count=0.
- LFSR step: Q <= {Q[WIDTH-2:0], ^(Q & TAPS)}. The pattern output is Q.
- Default sequence from 0001: 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, then back to 0001.
- seed_load, accepted in IDLE or DONE: Q <= seed on the next edge. An all-zero seed is illegal (lockup state) and is replaced by SEED. seed_load is ignored in RUN.
- IDLE:
  - start=1 with num_patterns!=0: latch the target, clear pattern_count, go to RUN.
  - start=1 with num_patterns=0: go directly to DONE, emit no patterns.
  - If seed_load and start are asserted in the same cycle, the seed load takes effect first; the first pattern is the new seed.
- RUN, each cycle with hold=0:
  - pattern_valid=1 and pattern=Q.
  - On the edge, Q steps and pattern_count increments.
  - Valid is combinational from state/hold; pattern is already registered. The first valid pattern is visible in the cycle after start is sampled.
- RUN, hold=1: pattern_valid=0; Q and pattern_count are frozen.
- RUN exit: when pattern_count reaches target-1 and an unheld cycle occurs, that cycle is the last valid one. The next state is DONE and pattern_count=target.
- DONE:
  - done=1, busy=0, pattern_valid=0.
  - Q holds the state following the last issued pattern, so a back-to-back run continues the sequence unless re-seeded.
  - start re-launches as in IDLE (done drops on the edge).
- abort, any state: next state is IDLE. pattern_valid drops the next cycle; Q and pattern_count are held. abort takes priority over start.
- Targets larger than 2^WIDTH-1 wrap the LFSR sequence (legal). pattern_count saturates at its maximum value.
- busy = (state==RUN). done and busy are never both 1.

Test Plan:
1. Reset, then start with num_patterns=15, hold=0 -> pattern_valid high for exactly 15 cycles. Patterns follow the 15-state list above from 0001. done=1 the cycle after the last pattern; pattern_count=15.
2. seed_load seed=4'b1010, then start with num_patterns=3 -> patterns 1010, 0101, 1011. Then seed_load seed=0000, start with num_patterns=1 -> pattern 0001.
3. In RUN with num_patterns=5, assert hold for 2 cycles after the 2nd pattern -> 0001, 0011, (2 cycles of valid=0, pattern frozen at 0111), 0111, 1111, 1110. Total 5 valids.
4. abort during the 4th pattern of a 10-pattern run -> state IDLE next cycle, busy=0, done=0, pattern_count=3. A fresh start then begins from the held LFSR state 1111.
5. start with num_patterns=0 -> no pattern_valid; done=1 one cycle later. Then start with num_patterns=2 from DONE -> 2 patterns continuing from the held LFSR state.
6. Assert reset low mid-run (asynchronously, between edges) -> outputs return to reset values immediately. After release, no activity until start.
